// File: rtl/riscv_pkg.sv
// Shared defaults for the fetch/decode pipeline: field widths and the
// values presented on the decode side while nothing valid is held.
package riscv_pkg;
  localparam int          DEF_XLEN      = 32;
  localparam int          DEF_ILEN      = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013; // ADDI x0,x0,0
  localparam logic [31:0] DEF_PC_RESET  = 32'h0000_0000;
endpackage

// File: rtl/if_id_pipeline_reg_pipe_entry.sv
// One storage slot of the IF/ID register: a valid bit plus a data word.
// Priority is kill (valid off, data to reset value) > load > clear (valid off only).
module pipe_entry #(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_kill,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic         o_v,
  output logic [W-1:0] o_q
);

  logic         r_v;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_q <= RST_VAL;
    end else if (i_kill) begin
      r_v <= 1'b0;
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_v <= 1'b1;
      r_q <= i_d;
    end else if (i_clr) begin
      r_v <= 1'b0;
    end
  end

  assign o_v = r_v;
  assign o_q = r_q;

endmodule

// File: rtl/if_id_pipeline_reg.sv
// IF/ID stage register with valid/ready handshake and a one-word skid slot,
// so a decode stall never drops a fetched word; flush kills both slots.
module if_id_pipeline_reg
  import riscv_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              ILEN      = DEF_ILEN,
  parameter logic [ILEN-1:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter logic [XLEN-1:0] PC_RESET  = DEF_PC_RESET
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instruction_fetch,
  input  logic [XLEN-1:0] pc_pre_address,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] pre_address
);

  localparam int W = XLEN + ILEN;
  localparam logic [W-1:0] ENTRY_RST = {PC_RESET, NOP_INSTR};

  logic         r_in_ready;
  logic         w_acc;
  logic         w_drain;
  logic         w_m_v;
  logic         w_s_v;
  logic [W-1:0] w_m_q;
  logic [W-1:0] w_s_q;
  logic [W-1:0] w_in;
  logic [W-1:0] w_m_d;
  logic         w_m_load;
  logic         w_m_clr;
  logic         w_m_sel_s;
  logic         w_s_load;
  logic         w_s_clr;
  logic         w_s_v_nxt;

  assign w_in    = {pc_pre_address, instruction_fetch};
  assign w_acc   = in_valid & r_in_ready;
  assign w_drain = w_m_v & out_ready;
  assign w_m_d   = w_m_sel_s ? w_s_q : w_in;

  always_comb begin
    w_m_load  = 1'b0;
    w_m_clr   = 1'b0;
    w_m_sel_s = 1'b0;
    w_s_load  = 1'b0;
    w_s_clr   = 1'b0;
    w_s_v_nxt = w_s_v;
    if (flush) begin
      w_s_v_nxt = 1'b0;
    end else if (!w_m_v || w_drain) begin
      if (w_s_v) begin
        // skid word moves up first so accept order is preserved
        w_m_load  = 1'b1;
        w_m_sel_s = 1'b1;
        w_s_load  = w_acc;
        w_s_clr   = ~w_acc;
        w_s_v_nxt = w_acc;
      end else if (w_acc) begin
        w_m_load = 1'b1;
      end else begin
        w_m_clr = 1'b1;
      end
    end else if (w_acc) begin
      w_s_load  = 1'b1;
      w_s_v_nxt = 1'b1;
    end
  end

  pipe_entry #(.W(W), .RST_VAL(ENTRY_RST)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_kill (flush),
    .i_load (w_m_load),
    .i_clr  (w_m_clr),
    .i_d    (w_m_d),
    .o_v    (w_m_v),
    .o_q    (w_m_q)
  );

  pipe_entry #(.W(W), .RST_VAL(ENTRY_RST)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_kill (flush),
    .i_load (w_s_load),
    .i_clr  (w_s_clr),
    .i_d    (w_in),
    .o_v    (w_s_v),
    .o_q    (w_s_q)
  );

  // Held low through reset so fetch sees ready only from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready <= 1'b0;
    else        r_in_ready <= ~w_s_v_nxt;
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = w_m_v;
  assign instruction = w_m_v ? w_m_q[ILEN-1:0] : NOP_INSTR;
  assign pre_address = w_m_q[W-1:ILEN];

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Directed and randomized checks of the IF/ID register against a queue model.
module tb_if_id_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction_fetch = '0;
  logic [31:0] pc_pre_address = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pre_address;

  int tests = 0;
  int fails = 0;

  if_id_pipeline_reg dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instruction_fetch (instruction_fetch),
    .pc_pre_address    (pc_pre_address),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .instruction       (instruction),
    .pre_address       (pre_address)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] iw(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc);
    in_valid          = 1'b1;
    pc_pre_address    = pc;
    instruction_fetch = iw(pc);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".pc"}, {32'd0, pre_address}, {32'd0, pc});
    chk({tag, ".instr"}, {32'd0, instruction}, {32'd0, iw(pc)});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ".nop"}, {32'd0, instruction}, 64'h13);
  endtask

  logic [63:0] sb[$];
  logic [63:0] held;
  logic        acc, drain, hold_chk;

  initial begin
    // reset state
    #1;
    chk("rst.valid", {63'd0, out_valid}, 64'd0);
    chk("rst.instr", {32'd0, instruction}, 64'h13);
    chk("rst.pc", {32'd0, pre_address}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);

    // T2 stream with decode always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'(i * 4));
      tick();
      chk_out($sformatf("stream%0d", i), 32'(i * 4));
      chk("stream.in_ready", {63'd0, in_ready}, 64'd1);
    end
    idle();
    tick();
    chk_empty("stream.end");

    // T3 stall fills the skid slot
    out_ready = 1'b0;
    send(32'h40);
    tick();
    chk_out("stall.m", 32'h40);
    chk("stall.rdy1", {63'd0, in_ready}, 64'd1);
    send(32'h44);
    tick();
    chk_out("stall.hold", 32'h40);
    chk("stall.rdy0", {63'd0, in_ready}, 64'd0);
    idle();
    tick();
    chk_out("stall.hold2", 32'h40);
    out_ready = 1'b1;
    tick();
    chk_out("stall.rel", 32'h44);
    chk("stall.rdy_back", {63'd0, in_ready}, 64'd1);
    tick();
    chk_empty("stall.done");

    // T4 flush with both slots full and a word offered
    out_ready = 1'b0;
    send(32'h80);
    tick();
    send(32'h84);
    tick();
    chk("flush.full", {63'd0, in_ready}, 64'd0);
    in_ready_force_accept: begin
      flush = 1'b1;
      send(32'h88);
      tick();
    end
    flush = 1'b0;
    idle();
    chk_empty("flush");
    chk("flush.pc", {32'd0, pre_address}, 64'h0);
    chk("flush.rdy", {63'd0, in_ready}, 64'd1);
    tick();
    chk_empty("flush.no88");
    out_ready = 1'b1;
    send(32'h100);
    tick();
    chk_out("flush.next", 32'h100);
    idle();
    tick();
    chk_empty("flush.after");

    // T5 skid full while decode releases and fetch keeps offering
    out_ready = 1'b0;
    send(32'hA0);
    tick();
    send(32'hA4);
    tick();
    out_ready = 1'b1;
    send(32'hA8);
    tick();
    chk_out("simul.a4", 32'hA4);
    chk("simul.rdy", {63'd0, in_ready}, 64'd1);
    tick();
    chk_out("simul.a8", 32'hA8);
    idle();
    tick();
    chk_empty("simul.end");

    // T1 async reset mid-stream with both slots full
    out_ready = 1'b0;
    send(32'hC0);
    tick();
    send(32'hC4);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk_empty("arst");
    chk("arst.pc", {32'd0, pre_address}, 64'h0);
    tick();
    chk_empty("arst.held");
    rst_n = 1'b1;
    tick();
    chk("arst.rdy", {63'd0, in_ready}, 64'd1);
    chk_empty("arst.after");

    // T6 random traffic against a queue model
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !in_ready)) begin
        if ($urandom_range(0, 99) < 60) send($urandom());
        else idle();
      end
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      chk("rnd.valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      chk("rnd.rdy", {63'd0, in_ready}, {63'd0, sb.size() < 2});
      if (sb.size() != 0)
        chk("rnd.data", {pre_address, instruction}, sb[0]);
      acc      = in_valid & in_ready;
      drain    = out_valid & out_ready;
      hold_chk = out_valid & !out_ready & !flush;
      held     = {pre_address, instruction};
      if (flush) sb.delete();
      else begin
        if (drain && sb.size() != 0) void'(sb.pop_front());
        if (acc) sb.push_back({pc_pre_address, instruction_fetch});
      end
      tick();
      if (hold_chk) begin
        chk("rnd.stable.v", {63'd0, out_valid}, 64'd1);
        chk("rnd.stable.d", {pre_address, instruction}, held);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
